// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue in front of an 8x8 register file.
// Accepts results over valid/ready, drains one entry per cycle onto the
// regfile write port, and forwards still-queued results to both read ports.
// Optional feature macro: REGFILE_WB_R0_ZERO_EN (register 0 hard-wired to zero).
module regfile_writeback #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [ADDR_W-1:0]       res_addr,
  input  logic [DATA_W-1:0]       res_data,
  input  logic                    wr_stall,
  output logic                    we,
  output logic [ADDR_W-1:0]       w_addr,
  output logic [DATA_W-1:0]       w_data,
  input  logic [ADDR_W-1:0]       q_addr_a,
  input  logic [ADDR_W-1:0]       q_addr_b,
  input  logic [DATA_W-1:0]       rf_data_a,
  input  logic [DATA_W-1:0]       rf_data_b,
  output logic [DATA_W-1:0]       fwd_data_a,
  output logic [DATA_W-1:0]       fwd_data_b,
  output logic [$clog2(DEPTH):0]  pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              push_en;
  logic              pop;

  assign full      = (pending == CNT_W'(DEPTH));
  assign empty     = (pending == '0);
  assign res_ready = !full;
  assign push      = res_valid && res_ready;
`ifdef REGFILE_WB_R0_ZERO_EN
  // Writes to register 0 are consumed but dropped.
  assign push_en   = push && (res_addr != '0);
`else
  assign push_en   = push;
`endif
  assign we        = !empty && !wr_stall;
  assign pop       = we;
  assign w_addr    = empty ? '0 : addr_mem[rd_ptr];
  assign w_data    = empty ? '0 : data_mem[rd_ptr];

  // Queue pointers and occupancy; reset discards every queued entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      pending <= pending + CNT_W'(push_en) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_mem[wr_ptr] <= res_addr;
      data_mem[wr_ptr] <= res_data;
    end
  end

  // Forwarding: walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_data_a = rf_data_a;
    fwd_data_b = rf_data_b;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < pending) begin
        if (addr_mem[rd_ptr + PTR_W'(i)] == q_addr_a) fwd_data_a = data_mem[rd_ptr + PTR_W'(i)];
        if (addr_mem[rd_ptr + PTR_W'(i)] == q_addr_b) fwd_data_b = data_mem[rd_ptr + PTR_W'(i)];
      end
    end
`ifdef REGFILE_WB_R0_ZERO_EN
    if (q_addr_a == '0) fwd_data_a = '0;
    if (q_addr_b == '0) fwd_data_b = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed checks of regfile_writeback
// against a queue-based reference model plus a behavioural register file.
module tb_regfile_writeback;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk;
  logic              reset;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              wr_stall;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] q_addr_a;
  logic [ADDR_W-1:0] q_addr_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic [1:0]        pending;

  logic [DATA_W-1:0] rf  [8];  // the register file the DUT writes
  logic [DATA_W-1:0] mrf [8];  // expected register file contents
  ent_t              mq [$];   // expected queue contents, oldest first

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_data(res_data),
    .wr_stall(wr_stall),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural regfile: synchronous write, combinational read.
  always @(posedge clk) begin
    if (we) rf[w_addr] <= w_data;
  end
  assign rf_data_a = rf[q_addr_a];
  assign rf_data_b = rf[q_addr_b];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd_model(input logic [ADDR_W-1:0] qa);
    logic [DATA_W-1:0] r;
`ifdef REGFILE_WB_R0_ZERO_EN
    if (qa == 0) return '0;
`endif
    r = mrf[qa];
    foreach (mq[i]) if (mq[i].a == qa) r = mq[i].d;
    return r;
  endfunction

  function automatic bit dropped(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_WB_R0_ZERO_EN
    return a == 0;
`else
    return 1'b0;
`endif
  endfunction

  // One cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic st, input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    logic e_ready, e_we;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd;
    @(negedge clk);
    res_valid = v; res_addr = a; res_data = d;
    wr_stall = st; q_addr_a = qa; q_addr_b = qb;
    #1;
    e_ready = (mq.size() < DEPTH);
    e_we    = (mq.size() != 0) && !st;
    e_wa    = (mq.size() != 0) ? mq[0].a : '0;
    e_wd    = (mq.size() != 0) ? mq[0].d : '0;
    check_eq("res_ready", res_ready, e_ready);
    check_eq("pending", pending, mq.size());
    check_eq("we", we, e_we);
    check_eq("w_addr", w_addr, e_wa);
    check_eq("w_data", w_data, e_wd);
    check_eq("fwd_a", fwd_data_a, fwd_model(qa));
    check_eq("fwd_b", fwd_data_b, fwd_model(qb));
    @(posedge clk);
    if (e_we) begin
      mrf[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (v && e_ready && !dropped(a)) mq.push_back('{a: a, d: d});
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] qa);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, qa, qa);
  endtask

  task automatic check_rf();
    @(negedge clk);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rf%0d", i), rf[i], mrf[i]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]  = 8'h10 + 8'(i);
      mrf[i] = 8'h10 + 8'(i);
    end
    reset = 1'b1; res_valid = 1'b0; res_addr = '0; res_data = '0;
    wr_stall = 1'b0; q_addr_a = '0; q_addr_b = '0;
    #1;
    check_eq("rst_pending", pending, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_w_addr", w_addr, 0);
    check_eq("rst_w_data", w_data, 0);
    check_eq("rst_ready", res_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Single push with idle queue: write port next cycle, regfile one later.
    step(1'b1, 3'd1, 8'hAA, 1'b0, 3'd1, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd1);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd1);
    check_eq("r1_after", rf[1], 8'hAA);

    // Stall fills the queue, then two back-to-back drains.
    step(1'b1, 3'd2, 8'h55, 1'b1, 3'd2, 3'd3);
    step(1'b1, 3'd3, 8'h11, 1'b1, 3'd2, 3'd3);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd3);
    idle(3, 3'd3);
    check_eq("r2_after", rf[2], 8'h55);
    check_eq("r3_after", rf[3], 8'h11);

    // Same-register pair under stall: newest forwarded, last value wins.
    step(1'b1, 3'd4, 8'h01, 1'b1, 3'd4, 3'd4);
    step(1'b1, 3'd4, 8'h02, 1'b1, 3'd4, 3'd4);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4);
    idle(3, 3'd4);
    check_eq("r4_after", rf[4], 8'h02);

    // Full queue with valid and drain active: rejected that cycle, accepted next.
    step(1'b1, 3'd5, 8'hA1, 1'b1, 3'd5, 3'd6);
    step(1'b1, 3'd6, 8'hA2, 1'b1, 3'd5, 3'd6);
    step(1'b1, 3'd7, 8'hA3, 1'b0, 3'd7, 3'd6);
    step(1'b1, 3'd7, 8'hA3, 1'b0, 3'd7, 3'd6);
    idle(3, 3'd7);
    check_rf();

    // Reset with two entries queued: write port drops at once, nothing commits.
    step(1'b1, 3'd2, 8'hE2, 1'b1, 3'd2, 3'd3);
    step(1'b1, 3'd3, 8'hE3, 1'b1, 3'd2, 3'd3);
    @(negedge clk);
    res_valid = 1'b0; wr_stall = 1'b0;
    #1;
    check_eq("pre_rst_we", we, 1);
    check_eq("pre_rst_pending", pending, 2);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_we", we, 0);
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_ready", res_ready, 1);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    check_eq("r2_kept", rf[2], 8'h55);
    check_eq("r3_kept", rf[3], 8'h11);
    check_rf();

`ifdef REGFILE_WB_R0_ZERO_EN
    // Register 0 writes are consumed but never queued; reads of 0 return zero.
    step(1'b1, 3'd0, 8'hFF, 1'b0, 3'd1, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    check_eq("r0_fwd_b", fwd_data_b, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
           ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end
    idle(4, 3'd0);
    check_rf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 8-entry x 8-bit register file.
- Accepts execute/load results over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle onto the regfile's single synchronous write port (we/w_addr/w_data).
- Forwards still-pending results to the two read ports, so decode never reads a stale value.

Parameters:
- DATA_W, 8, data width; matches regfile w_data.
- ADDR_W, 3, register address width; matches regfile w_addr.
- DEPTH, 2, queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears queue.
- res_valid  in  1  result available.
- res_ready  out  1  queue can accept a result.
- res_addr  in  ADDR_W  destination register.
- res_data  in  DATA_W  result value.
- wr_stall  in  1  another agent owns the write port; hold the drain.
- we  out  1  regfile write enable.
- w_addr  out  ADDR_W  regfile write address.
- w_data  out  DATA_W  regfile write data.
- q_addr_a  in  ADDR_W  read address A (same value driven to regfile r_addr_a).
- q_addr_b  in  ADDR_W  read address B (same value driven to regfile r_addr_b).
- rf_data_a  in  DATA_W  regfile r_data_a.
- rf_data_b  in  DATA_W  regfile r_data_b.
- fwd_data_a  out  DATA_W  forwarded read data A.
- fwd_data_b  out  DATA_W  forwarded read data B.
- pending  out  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - Queue empty, wr_ptr = rd_ptr = 0, pending = 0.
  - we = 0, w_addr = 0, w_data = 0, res_ready = 1.
- Reset asserted mid-operation:
  - All queued writes are discarded immediately and never reach the regfile.
  - we drops to 0 without waiting for a clock edge.
- Storage: circular FIFO with pointer wrap at DEPTH and an occupancy counter. full = (pending == DEPTH); empty = (pending == 0).
- Push: res_valid && res_ready at posedge writes {res_addr, res_data} at wr_ptr.
- res_ready = !full, registered-state only, with no combinational path from wr_stall or res_valid. When full, no push that cycle even if a pop occurs.
- Write port is driven combinationally from the head entry:
  - we = !empty && !wr_stall.
  - w_addr/w_data = head entry when not empty, else 0.
- Pop: occurs at the posedge where we = 1. The regfile commits the entry at that same edge.
- Latency: a result accepted at edge N is driven on the write port during cycle N+1 and committed at edge N+1 when the queue was empty and unstalled. Each older entry or stall cycle adds one cycle.
- Simultaneous push and pop: pending is unchanged; both pointers advance.
- Ordering: strictly in order. Two results to the same register commit in acceptance order, so the last accepted value wins.
- Forwarding (combinational):
  - fwd_data_x = data of the NEWEST queued entry whose addr == q_addr_x; otherwise rf_data_x.
  - The entry currently on the write port (being committed this edge) is included.
  - Entries accepted in the current cycle are not forwarded until after the push edge.
- Stall: wr_stall = 1 freezes the drain only. Pushes continue until full; forwarding stays active.
- pending is reported in range 0..DEPTH.

Optional Feature:
- Macro: REGFILE_WB_R0_ZERO_EN.
- Defined:
  - Register 0 is hard-wired zero.
  - A result with res_addr == 0 is handshaken (consumed) but never enqueued, so pending is unchanged and we is never asserted for it.
  - fwd_data_x = 0 whenever q_addr_x == 0, regardless of rf_data_x.
- Undefined: register 0 is an ordinary register with no special handling.

Test Plan:
- Reset, then push R1=0xAA with queue idle -> we=1, w_addr=1, w_data=0xAA in the next cycle; regfile R1 reads 0xAA one cycle later; pending returns to 0.
- Hold wr_stall=1, push R2=0x55 and R3=0x11 -> pending=2, res_ready=0, we=0. Release stall -> two consecutive write cycles, R2 then R3, and res_ready=1 again.
- With stall held, push R4=0x01 then R4=0x02, q_addr_a=4 -> fwd_data_a=0x02 while rf_data_a still shows old. After drain, R4 reads 0x02.
- Queue full plus res_valid=1 with wr_stall=0 -> no accept that cycle. Accept on the following cycle; order preserved, no data loss.
- Two entries pending, assert reset for one cycle -> we falls immediately, pending=0, neither register changes value.
- REGFILE_WB_R0_ZERO_EN defined: push R0=0xFF -> res_ready=1, pending stays 0, we never asserts, fwd_data_b=0 with q_addr_b=0.
